adc_sample_conditioner: RTL and testbench

- Upstream stage of the level-trigger capture block; produces the 12-bit `data_output` sample stream that the trigger samples as its `data_input`.
- Services the XADC end-of-conversion pulse and performs a DRP read of one fixed channel.
- Box-car averages 2^AVG_LOG2 conversions and presents the held averaged value, plus a one-cycle `data_valid` strobe.
- Flags DRP timeouts and conversion overruns so the capture path never stalls.

---
 rtl/adc_sample_conditioner.sv | 176 +++++++++++++++++
 tb/tb_adc_sample_conditioner.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_sample_conditioner.sv
// adc_sample_conditioner
//   Services the XADC end-of-conversion pulse with a DRP read of one fixed
//   channel, box-car averages 2**AVG_LOG2 results and presents the held
//   average with a one-cycle data_valid strobe. DRP timeouts and lost
//   conversions are reported through sticky flags so the capture path never
//   stalls waiting on the ADC.
//
//   Optional build macro ADC_OFFSET_CAL_EN: adds a signed offset_in port that
//   is added to the averaged value and saturated to 0..4095. This costs one
//   extra pipeline stage (drdy-to-data_valid latency 3 edges instead of 2).
module adc_sample_conditioner #(
   parameter logic [6:0] CHANNEL_ADDR   = 7'h03,
   parameter int         AVG_LOG2       = 2,
   parameter int         TIMEOUT_CYCLES = 64
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               eoc_in,
   input  logic               drdy_in,
   input  logic [15:0]        do_in,
`ifdef ADC_OFFSET_CAL_EN
   input  logic signed [11:0] offset_in,
`endif
   output logic               den_out,
   output logic               dwe_out,
   output logic [6:0]         daddr_out,
   output logic [15:0]        di_out,
   output logic [11:0]        data_output,
   output logic               data_valid,
   output logic               drdy_timeout,
   output logic               overrun
);

   localparam int               ACC_W    = 12 + AVG_LOG2;
   localparam int               CNT_W    = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);
   localparam logic [7:0]       TO_LAST  = 8'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, ACC} state_t;

   state_t           state;
   logic             pending;
   logic [7:0]       tcnt;
   logic [11:0]      raw;
   logic [ACC_W-1:0] acc;
   logic [CNT_W-1:0] cnt;
   logic [ACC_W-1:0] sum;
   logic [11:0]      avg_q;
   logic             avg_vld;

   // The read path never writes the DRP.
   assign dwe_out = 1'b0;
   assign di_out  = 16'h0000;

   // The DRP result is left-justified; the low nibble carries no data.
   logic unused_do_bits;
   assign unused_do_bits = ^do_in[3:0];

   // Width of the accumulator guarantees 2**AVG_LOG2 full-scale samples fit.
   assign sum = acc + ACC_W'(raw);

   // Conversion sequencer: eoc bookkeeping, DRP handshake, timeout and averaging.
   always_ff @(posedge clk) begin
      // NOTE: clocked state uses non-blocking assignments only, so every
      // register here sees the pre-edge value of every other register.
      if (rst) begin
         state        <= IDLE;
         pending      <= 1'b0;
         tcnt         <= '0;
         raw          <= '0;
         acc          <= '0;
         cnt          <= '0;
         den_out      <= 1'b0;
         daddr_out    <= '0;
         drdy_timeout <= 1'b0;
         overrun      <= 1'b0;
         avg_q        <= '0;
         avg_vld      <= 1'b0;
      end else begin
         den_out <= 1'b0;
         avg_vld <= 1'b0;

         // A conversion finishing while a read is in flight is queued once;
         // a second one before the queue drains is lost and flagged.
         if (state != IDLE && eoc_in) begin
            if (pending) overrun <= 1'b1;
            else         pending <= 1'b1;
         end

         case (state)
            IDLE: begin
               if (eoc_in || pending) begin
                  state     <= REQ;
                  den_out   <= 1'b1;
                  daddr_out <= CHANNEL_ADDR;
                  // Leaving on a queued request while a fresh eoc arrives
                  // re-queues that eoc instead of dropping it.
                  pending   <= pending & eoc_in;
               end
            end
            REQ: begin
               state <= WAIT;
               tcnt  <= '0;
            end
            WAIT: begin
               if (drdy_in) begin
                  raw   <= do_in[15:4];
                  state <= ACC;
               end else if (tcnt == TO_LAST) begin
                  drdy_timeout <= 1'b1;
                  state        <= IDLE;
               end else begin
                  tcnt <= tcnt + 8'd1;
               end
            end
            ACC: begin
               if (cnt == CNT_LAST) begin
                  avg_q   <= 12'(sum >> AVG_LOG2);
                  avg_vld <= 1'b1;
                  acc     <= '0;
                  cnt     <= '0;
               end else begin
                  acc <= sum;
                  cnt <= cnt + 1'b1;
               end
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef ADC_OFFSET_CAL_EN
   logic signed [13:0] cal_sum;
   logic [11:0]        cal_sat;
   logic [11:0]        cal_q;
   logic               cal_vld;

   assign cal_sum = $signed({2'b00, avg_q}) + $signed({{2{offset_in[11]}}, offset_in});

   // Clamp the offset-corrected average into the unsigned 12-bit range.
   always_comb begin
      // NOTE: default assignment first so this block can never infer a latch.
      cal_sat = cal_sum[11:0];
      if (cal_sum < 14'sd0)         cal_sat = 12'h000;
      else if (cal_sum > 14'sd4095) cal_sat = 12'hFFF;
   end

   // Calibration stage followed by the held output register.
   always_ff @(posedge clk) begin
      if (rst) begin
         cal_q       <= '0;
         cal_vld     <= 1'b0;
         data_output <= '0;
         data_valid  <= 1'b0;
      end else begin
         cal_vld    <= avg_vld;
         data_valid <= cal_vld;
         if (avg_vld) cal_q       <= cal_sat;
         if (cal_vld) data_output <= cal_q;
      end
   end
`else
   // Held output register, updated only when a new average is ready.
   always_ff @(posedge clk) begin
      if (rst) begin
         data_output <= '0;
         data_valid  <= 1'b0;
      end else begin
         data_valid <= avg_vld;
         if (avg_vld) data_output <= avg_q;
      end
   end
`endif

endmodule

// File: tb/tb_adc_sample_conditioner.sv
// tb_adc_sample_conditioner
//   Two instances share one stimulus stream: u_dut0 passes every conversion
//   through (AVG_LOG2=0), u_dut2 averages four (AVG_LOG2=2). Inputs change
//   and outputs are sampled on the falling clock edge.
//   Honours ADC_OFFSET_CAL_EN the same way the design does.
module tb_adc_sample_conditioner;

`ifdef ADC_OFFSET_CAL_EN
   localparam int LAT = 3;
`else
   localparam int LAT = 2;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        eoc_in = 1'b0;
   logic        drdy_in = 1'b0;
   logic [15:0] do_in = '0;
`ifdef ADC_OFFSET_CAL_EN
   logic signed [11:0] offset_in = '0;
`endif

   logic        den0, dwe0, dv0, to0, ov0;
   logic [6:0]  daddr0;
   logic [15:0] di0;
   logic [11:0] dout0;
   logic        den2, dwe2, dv2, to2, ov2;
   logic [6:0]  daddr2;
   logic [15:0] di2;
   logic [11:0] dout2;

   always #5 clk = ~clk;

   adc_sample_conditioner #(.CHANNEL_ADDR(7'h03), .AVG_LOG2(0), .TIMEOUT_CYCLES(64)) u_dut0 (
      .clk(clk), .rst(rst), .eoc_in(eoc_in), .drdy_in(drdy_in), .do_in(do_in),
`ifdef ADC_OFFSET_CAL_EN
      .offset_in(offset_in),
`endif
      .den_out(den0), .dwe_out(dwe0), .daddr_out(daddr0), .di_out(di0),
      .data_output(dout0), .data_valid(dv0), .drdy_timeout(to0), .overrun(ov0)
   );

   adc_sample_conditioner #(.CHANNEL_ADDR(7'h03), .AVG_LOG2(2), .TIMEOUT_CYCLES(64)) u_dut2 (
      .clk(clk), .rst(rst), .eoc_in(eoc_in), .drdy_in(drdy_in), .do_in(do_in),
`ifdef ADC_OFFSET_CAL_EN
      .offset_in(offset_in),
`endif
      .den_out(den2), .dwe_out(dwe2), .daddr_out(daddr2), .di_out(di2),
      .data_output(dout2), .data_valid(dv2), .drdy_timeout(to2), .overrun(ov2)
   );

   int n_tests = 0;
   int n_fail  = 0;
   int den_cnt = 0;

   // Count DRP enable pulses seen by the passthrough instance.
   always @(negedge clk) if (den0) den_cnt++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Pulse eoc from IDLE and confirm the single-cycle DRP request.
   task automatic start_read(input string name);
      eoc_in = 1'b1;
      @(negedge clk);
      eoc_in = 1'b0;
      check({name, " den"}, 32'(den0), 32'd1);
      check({name, " daddr"}, 32'(daddr0), 32'h03);
   endtask

   // Return DRP data after dly cycles and check the output strobe timing.
   // exp2v < 0 skips the averaging instance; eoc_at > 0 raises eoc so it is
   // captured on edge T+eoc_at (T = edge that sees drdy).
   task automatic finish_read(input string name, input logic [15:0] dval, input int dly,
                              input logic [11:0] exp0, input int exp2v,
                              input logic [11:0] exp2d, input int eoc_at);
      int          v0_n, v0_at, v2_n;
      logic [11:0] d0, d2;
      v0_n = 0; v0_at = 0; v2_n = 0; d0 = '0; d2 = '0;
      repeat (dly) @(negedge clk);
      drdy_in = 1'b1;
      do_in   = dval;
      @(negedge clk);
      drdy_in = 1'b0;
      do_in   = '0;
      for (int k = 1; k <= LAT + 1; k++) begin
         eoc_in = (k == eoc_at);
         @(negedge clk);
         if (dv0) begin v0_n++; v0_at = k; d0 = dout0; end
         if (dv2) begin v2_n++; d2 = dout2; end
      end
      eoc_in = 1'b0;
      check({name, " valid count"}, 32'(v0_n), 32'd1);
      check({name, " valid latency"}, 32'(v0_at), 32'(LAT));
      check({name, " data"}, 32'(d0), 32'(exp0));
      if (exp2v >= 0) begin
         check({name, " avg valid count"}, 32'(v2_n), 32'(exp2v));
         if (exp2v == 1) check({name, " avg data"}, 32'(d2), 32'(exp2d));
      end
   endtask

   typedef struct packed {
      logic [15:0] dval;
      int          dly;
      logic [11:0] exp0;
      int          exp2v;
      logic [11:0] exp2d;
   } vec_t;

   vec_t vecs [8];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      int nv;

      // Raw 100,101,102,104 average to 407>>2 = 101; then ABC,FFF,000,123
      // sum to 7134, 7134>>2 = 1783 = 0x6F7.
      vecs[0] = '{16'h0640, 1, 12'h064, 0, 12'h000};
      vecs[1] = '{16'h065F, 2, 12'h065, 0, 12'h000};
      vecs[2] = '{16'h0663, 5, 12'h066, 0, 12'h000};
      vecs[3] = '{16'h0687, 3, 12'h068, 1, 12'h065};
      vecs[4] = '{16'hABC0, 3, 12'hABC, 0, 12'h000};
      vecs[5] = '{16'hFFFF, 1, 12'hFFF, 0, 12'h000};
      vecs[6] = '{16'h000F, 2, 12'h000, 0, 12'h000};
      vecs[7] = '{16'h1234, 4, 12'h123, 1, 12'h6F7};

      repeat (3) @(negedge clk);
      rst = 1'b0;
      check("reset data_output", 32'(dout0), 32'h0);
      check("reset data_valid", 32'(dv0), 32'h0);
      check("reset den", 32'(den0), 32'h0);
      check("reset daddr", 32'(daddr0), 32'h0);
      check("reset dwe/di", {15'h0, dwe0, di0}, 32'h0);
      check("reset flags", {30'h0, to0, ov0}, 32'h0);
      check("reset avg data", 32'(dout2), 32'h0);

      for (int i = 0; i < 8; i++) begin
         start_read($sformatf("vec%0d", i));
         finish_read($sformatf("vec%0d", i), vecs[i].dval, vecs[i].dly,
                     vecs[i].exp0, vecs[i].exp2v, vecs[i].exp2d, 0);
      end
      check("dwe held low", 32'(dwe0), 32'h0);
      check("daddr held", 32'(daddr0), 32'h03);

      // DRP never answers: 64 WAIT cycles, then timeout and back to IDLE.
      start_read("timeout");
      repeat (64) @(negedge clk);
      check("timeout not yet", 32'(to0), 32'h0);
      @(negedge clk);
      check("timeout set", 32'(to0), 32'h1);
      drdy_in = 1'b1;
      do_in   = 16'hFFF0;
      @(negedge clk);
      drdy_in = 1'b0;
      do_in   = '0;
      nv = 0;
      repeat (4) begin
         @(negedge clk);
         if (dv0) nv++;
      end
      check("stray drdy ignored", 32'(nv), 32'h0);
      start_read("after timeout");
      finish_read("after timeout", 16'h8000, 2, 12'h800, -1, 12'h000, 0);
      check("timeout sticky", 32'(to0), 32'h1);

      // Three eoc while waiting: one queued, two lost.
      base = den_cnt;
      start_read("ovr");
      @(negedge clk);
      eoc_in = 1'b1; @(negedge clk); eoc_in = 1'b0;
      check("single queued eoc no overrun", 32'(ov0), 32'h0);
      eoc_in = 1'b1; @(negedge clk); eoc_in = 1'b0;
      @(negedge clk);
      eoc_in = 1'b1; @(negedge clk); eoc_in = 1'b0;
      check("overrun set", 32'(ov0), 32'h1);
      finish_read("ovr first", 16'h2220, 1, 12'h222, -1, 12'h000, 0);
      finish_read("ovr queued", 16'h3330, 1, 12'h333, -1, 12'h000, 0);
      repeat (4) @(negedge clk);
      check("ovr den pulses", 32'(den_cnt - base), 32'd2);

      // Reset in WAIT, then a late drdy: nothing comes out, flags clear.
      start_read("rst");
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      drdy_in = 1'b1;
      do_in   = 16'h9990;
      @(negedge clk);
      drdy_in = 1'b0;
      do_in   = '0;
      nv = 0;
      repeat (4) begin
         @(negedge clk);
         if (dv0 || dv2) nv++;
      end
      check("rst late drdy no valid", 32'(nv), 32'h0);
      check("rst data_output", 32'(dout0), 32'h0);
      check("rst den/daddr", {24'h0, den0, daddr0}, 32'h0);
      check("rst flags", {30'h0, to0, ov0}, 32'h0);

      // Queue drains on the same edge a new eoc arrives: re-queued, no loss.
      base = den_cnt;
      start_read("race");
      @(negedge clk);
      eoc_in = 1'b1; @(negedge clk); eoc_in = 1'b0;
      finish_read("race a", 16'h4440, 1, 12'h444, -1, 12'h000, 2);
      finish_read("race b", 16'h5550, 1, 12'h555, -1, 12'h000, 0);
      finish_read("race c", 16'h6660, 1, 12'h666, -1, 12'h000, 0);
      repeat (3) @(negedge clk);
      check("race den pulses", 32'(den_cnt - base), 32'd3);
      check("race no overrun", 32'(ov0), 32'h0);
      // Fourth conversion since reset: (444+555+666+777)h = 6006, >>2 = 0x5DD.
      start_read("post rst avg");
      finish_read("post rst avg", 16'h7770, 2, 12'h777, 1, 12'h5DD, 0);

`ifdef ADC_OFFSET_CAL_EN
      offset_in = -12'sd50;
      start_read("offset neg");
      finish_read("offset neg", 16'h01E0, 2, 12'h000, -1, 12'h000, 0);
      offset_in = 12'sd100;
      start_read("offset pos");
      finish_read("offset pos", 16'hFFA0, 2, 12'hFFF, -1, 12'h000, 0);
      offset_in = 12'sd0;
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
